glb_bus_stim_gen: RTL
=====================

Name: glb_bus_stim_gen

Overview:
- Parametrised stimulus generator for the global-buffer-to-PE bus. Produces bursts of ifmap, filter and psum words for NUM_COL columns, with selectable data modes.
- Adds a valid/ready handshake, programmable burst length, and round-robin ID/TAG sequencing.
- Random mode uses a synthesizable, seedable LFSR, so the block can run in simulation benches and in on-board self-test.

Parameters:
- DATA_WIDTH, 16: ifmap/fltr word width; legal range 4..16. psum is 2*DATA_WIDTH.
- NUM_COL, 4: number of PE columns addressed by id.
- MAX_BURST, 256: maximum beats per burst.
- SEED, 32'hACE1_1234: LFSR reset value. A value of 0 is forced to 1.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request to begin a burst.
- mode  in  2  0=RAND, 1=INCR, 2=CONST, 3=ZERO.
- const_val  in  DATA_WIDTH  value used in CONST mode.
- burst_len  in  $clog2(MAX_BURST)+1  number of beats in the burst.
- ready  in  1  sink accepts the current beat.
- valid  out  1  beat present on the bus.
- ifmap_data  out  DATA_WIDTH  ifmap word.
- fltr_data  out  DATA_WIDTH  filter word.
- psum_data  out  2*DATA_WIDTH  psum word.
- id  out  $clog2(NUM_COL)+1  target column of the current beat.
- tag  out  $clog2(NUM_COL)+1  row tag of the current beat.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse when the burst completes.

Behaviour:
- Reset (asynchronous): state=IDLE; valid, busy, done, data, id, tag, beat counter all 0; LFSR=SEED. Reset mid-burst aborts immediately, and no done pulse is issued.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN: on start with burst_len!=0.
  - mode, const_val and burst_len are latched; burst_len>MAX_BURST is clamped to MAX_BURST.
  - start with burst_len==0 is ignored and the block stays in IDLE.
- Latency: start at cycle N gives valid=1 with the first beat's data at N+1.
- Transfer = valid && ready at a posedge.
  - While valid && !ready, all outputs hold stable.
  - start is ignored outside IDLE.
- On each transfer:
  - the beat counter increments;
  - id advances 0..NUM_COL-1 and wraps to 0;
  - when id wraps, tag increments, modulo 2^width;
  - the next beat's data is presented in the following cycle, with no bubble.
- RUN -> DONE: on the transfer of beat burst_len. In DONE, valid=0 and done=1 for one cycle; the next cycle returns to IDLE.
- id and tag restart at 0 for every burst.
- RAND mode:
  - 32-bit Galois LFSR, polynomial 0x80200003, stepped once per transfer and once when entering RUN.
  - ifmap = lfsr[DATA_WIDTH-1:0]; fltr = lfsr[16+DATA_WIDTH-1:16]; psum = lfsr[2*DATA_WIDTH-1:0].
  - An ifmap or fltr value of 0 is replaced by 1, so these words are never zero.
  - The LFSR is not reseeded between bursts; the sequence continues.
- INCR mode:
  - First beat: ifmap=fltr=psum=1.
  - Each transfer adds 1 to each word; all-ones wraps to 1, skipping 0.
- CONST mode: ifmap=fltr=const_val; psum = const_val zero-extended to 2*DATA_WIDTH.
- ZERO mode: all data words are 0.

Optional Feature:
- Macro GLB_STIM_CHECKSUM_EN.
- Defined:
  - adds output checksum, width 2*DATA_WIDTH, reset to 0 and cleared on IDLE->RUN;
  - on each transfer: checksum <= checksum ^ {fltr_data, ifmap_data};
  - the value is stable from the done pulse until the next start.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package glb_stim_pkg: mode_e enum (RAND, INCR, CONST, ZERO), state_e enum (IDLE, RUN, DONE), LFSR_POLY=32'h80200003, DEFAULT_SEED.
- Sub-module glb_lfsr32: clk, rstn, step, seed parameter, 32-bit state out.
- Top block: FSM, counters, data mux.

Test Plan:
- INCR, burst_len=6, NUM_COL=4, ready held 1 -> ifmap 1..6 on consecutive cycles; id 0,1,2,3,0,1; tag 0,0,0,0,1,1; done pulses one cycle after beat 6.
- CONST const_val=16'h00A5, burst_len=3, ready toggling 1,0,0,1,1 -> outputs stable during ready=0; exactly 3 transfers; psum=32'h000000A5.
- RAND, burst_len=200 -> data matches the bench LFSR model from SEED; no ifmap or fltr equal to 0; a second burst continues the sequence rather than restarting it.
- start with burst_len=0 -> no valid, no done, busy stays 0. burst_len=300 with MAX_BURST=256 -> exactly 256 transfers.
- rstn asserted at beat 3 of 10 -> valid, busy and data go to 0 asynchronously; no done; a subsequent start runs a full burst with id restarting at 0.
- With GLB_STIM_CHECKSUM_EN, INCR, burst_len=2, DATA_WIDTH=16 -> checksum = 32'h00010001 ^ 32'h00020002 = 32'h00030003.

Source files
------------

// File: rtl/glb_bus_stim_gen_pkg.sv
// Shared types, LFSR polynomial and step function for the GLB-to-PE bus stimulus generator.
// Pure definitions: no latency, no backpressure.
package glb_stim_pkg;

   typedef enum logic [1:0] {
      RAND  = 2'd0,
      INCR  = 2'd1,
      CONST = 2'd2,
      ZERO  = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam logic [31:0] LFSR_POLY    = 32'h8020_0003;
   localparam logic [31:0] DEFAULT_SEED = 32'hACE1_1234;

   // Right-shifting Galois step: the bit shifted out folds the tap mask back in.
   function automatic logic [31:0] lfsr_next(input logic [31:0] s);
      return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'd0);
   endfunction

endpackage

// File: rtl/glb_bus_stim_gen_if.sv
// Beat bus from the stimulus generator to the PE columns: data words plus id/tag.
// Valid/ready handshake; the master holds every field while valid && !ready.
interface glb_bus_stim_gen_if #(
   parameter int DATA_WIDTH = 16,
   parameter int NUM_COL    = 4
);
   localparam int IDW = $clog2(NUM_COL) + 1;

   logic                    valid;
   logic                    ready;
   logic [DATA_WIDTH-1:0]   ifmap_data;
   logic [DATA_WIDTH-1:0]   fltr_data;
   logic [2*DATA_WIDTH-1:0] psum_data;
   logic [IDW-1:0]          id;
   logic [IDW-1:0]          tag;

   modport master (
      output valid, ifmap_data, fltr_data, psum_data, id, tag,
      input  ready
   );

   modport slave (
      input  valid, ifmap_data, fltr_data, psum_data, id, tag,
      output ready
   );
endinterface

// File: rtl/glb_bus_stim_gen_lfsr32.sv
// Seedable 32-bit Galois LFSR; a zero seed is forced to 1 so the register never locks up.
// Advances one step on the clock edge where step is high; no backpressure.
module glb_lfsr32
   import glb_stim_pkg::*;
#(
   parameter logic [31:0] SEED = DEFAULT_SEED
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        step,
   output logic [31:0] state
);
   localparam logic [31:0] INIT = (SEED == 32'd0) ? 32'd1 : SEED;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)     state <= INIT;
      else if (step) state <= lfsr_next(state);
   end
endmodule

// File: rtl/glb_bus_stim_gen.sv
// Burst stimulus generator for the GLB-to-PE bus (RAND/INCR/CONST/ZERO); GLB_STIM_CHECKSUM_EN adds a checksum port.
// First beat one cycle after start, back-to-back beats after that; holds all outputs while ready is low.
module glb_bus_stim_gen
   import glb_stim_pkg::*;
#(
   parameter int          DATA_WIDTH = 16,
   parameter int          NUM_COL    = 4,
   parameter int          MAX_BURST  = 256,
   parameter logic [31:0] SEED       = DEFAULT_SEED
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic                         start,
   input  logic [1:0]                   mode,
   input  logic [DATA_WIDTH-1:0]        const_val,
   input  logic [$clog2(MAX_BURST):0]   burst_len,
   output logic                         busy,
   output logic                         done,
   glb_bus_stim_gen_if.master           bus
`ifdef GLB_STIM_CHECKSUM_EN
  ,output logic [2*DATA_WIDTH-1:0]      checksum
`endif
);
   localparam int DW  = DATA_WIDTH;
   localparam int PW  = 2 * DATA_WIDTH;
   localparam int BLW = $clog2(MAX_BURST) + 1;
   localparam int IDW = $clog2(NUM_COL) + 1;
   localparam logic [BLW-1:0] MAX_LEN  = BLW'(MAX_BURST);
   localparam logic [IDW-1:0] LAST_COL = IDW'(NUM_COL - 1);

   state_e          state_q, state_d;
   mode_e           mode_q, mode_sel;
   logic [DW-1:0]   const_q, const_sel;
   logic [BLW-1:0]  len_q, beat_q;
   logic [DW-1:0]   ifmap_q, fltr_q, ifmap_d, fltr_d;
   logic [PW-1:0]   psum_q, psum_d;
   logic [IDW-1:0]  id_q, tag_q;
   logic [31:0]     lfsr_q, lfsr_nxt;
   logic            launch, xfer, last, lfsr_step;

   assign launch = (state_q == IDLE) && start && (burst_len != '0);
   assign xfer   = (state_q == RUN) && bus.ready;
   assign last   = xfer && (beat_q == len_q - BLW'(1));

   assign mode_sel  = launch ? mode_e'(mode) : mode_q;
   assign const_sel = launch ? const_val : const_q;

   // The LFSR only moves for RAND bursts, so other modes leave the sequence untouched.
   assign lfsr_step = (launch || xfer) && (mode_sel == RAND);
   assign lfsr_nxt  = lfsr_next(lfsr_q);

   glb_lfsr32 #(.SEED(SEED)) u_lfsr (
      .clk   (clk),
      .rstn  (rstn),
      .step  (lfsr_step),
      .state (lfsr_q)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (launch) state_d = RUN;
         RUN:     if (last)   state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ifmap_d = ifmap_q;
      fltr_d  = fltr_q;
      psum_d  = psum_q;
      unique case (mode_sel)
         RAND: begin
            ifmap_d = (lfsr_nxt[DW-1:0] == '0) ? DW'(1) : lfsr_nxt[DW-1:0];
            fltr_d  = (lfsr_nxt[16+DW-1:16] == '0) ? DW'(1) : lfsr_nxt[16+DW-1:16];
            psum_d  = lfsr_nxt[PW-1:0];
         end
         INCR: begin
            if (launch) begin
               ifmap_d = DW'(1);
               fltr_d  = DW'(1);
               psum_d  = PW'(1);
            end else begin
               ifmap_d = (&ifmap_q) ? DW'(1) : ifmap_q + DW'(1);
               fltr_d  = (&fltr_q)  ? DW'(1) : fltr_q + DW'(1);
               psum_d  = (&psum_q)  ? PW'(1) : psum_q + PW'(1);
            end
         end
         CONST: begin
            ifmap_d = const_sel;
            fltr_d  = const_sel;
            psum_d  = PW'(const_sel);
         end
         default: begin
            ifmap_d = '0;
            fltr_d  = '0;
            psum_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         mode_q  <= RAND;
         const_q <= '0;
         len_q   <= '0;
         beat_q  <= '0;
         id_q    <= '0;
         tag_q   <= '0;
         ifmap_q <= '0;
         fltr_q  <= '0;
         psum_q  <= '0;
      end else begin
         if (launch) begin
            mode_q  <= mode_e'(mode);
            const_q <= const_val;
            len_q   <= (burst_len > MAX_LEN) ? MAX_LEN : burst_len;
            beat_q  <= '0;
            id_q    <= '0;
            tag_q   <= '0;
         end else if (xfer) begin
            beat_q <= beat_q + BLW'(1);
            if (id_q == LAST_COL) begin
               id_q  <= '0;
               tag_q <= tag_q + IDW'(1);
            end else begin
               id_q <= id_q + IDW'(1);
            end
         end
         // The final beat stays on the bus after completion; only the LFSR moves on.
         if (launch || (xfer && !last)) begin
            ifmap_q <= ifmap_d;
            fltr_q  <= fltr_d;
            psum_q  <= psum_d;
         end
      end
   end

`ifdef GLB_STIM_CHECKSUM_EN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)       checksum <= '0;
      else if (launch) checksum <= '0;
      else if (xfer)   checksum <= checksum ^ {fltr_q, ifmap_q};
   end
`endif

   assign bus.valid      = (state_q == RUN);
   assign bus.ifmap_data = ifmap_q;
   assign bus.fltr_data  = fltr_q;
   assign bus.psum_data  = psum_q;
   assign bus.id         = id_q;
   assign bus.tag        = tag_q;
   assign busy           = (state_q != IDLE);
   assign done           = (state_q == DONE);
endmodule
